// File: rtl/mmu_pkg.sv
// Shared MMU types and constants: walker FSM states, PTE flag bit positions
// and access-type encodings.
package mmu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L0_REQ  = 3'd3,
    L0_WAIT = 3'd4,
    RESP    = 3'd5
  } ptw_state_t;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;

  localparam logic [1:0] ACC_READ  = 2'd0;
  localparam logic [1:0] ACC_WRITE = 2'd1;
  localparam logic [1:0] ACC_EXEC  = 2'd2;

endpackage

// File: rtl/page_table_walker_if.sv
// PTE memory read bus. memReq/memAddr are held from request until the single
// cycle in which memValid=1 carries memRdata; there is no separate ready.
interface page_table_walker_if;

  logic        memReq;
  logic [31:0] memAddr;
  logic        memValid;
  logic [31:0] memRdata;

  modport master (output memReq, output memAddr, input memValid, input memRdata);
  modport slave  (input memReq, input memAddr, output memValid, output memRdata);

endinterface

// File: rtl/pte_check.sv
// Combinational PTE decode: validity, leaf/pointer, permission and superpage
// alignment. Level-1 leaves are legal only when PTW_SUPERPAGE_EN is defined.
module pte_check
  import mmu_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [9:0] i_ppn0,
  input  logic       i_level1,
  input  logic [1:0] i_acc,
  output logic       o_pointer,
  output logic       o_fault
);

  logic w_invalid;
  logic w_leaf;
  logic w_perm_ok;
  logic w_super_ok;

  assign w_invalid = !i_flags[PTE_V] || (!i_flags[PTE_R] && i_flags[PTE_W]);
  assign w_leaf    = i_flags[PTE_R] || i_flags[PTE_X];

  always_comb begin
    w_perm_ok = 1'b0;
    case (i_acc)
      ACC_READ:  w_perm_ok = i_flags[PTE_R];
      ACC_WRITE: w_perm_ok = i_flags[PTE_W];
      ACC_EXEC:  w_perm_ok = i_flags[PTE_X];
      default:   w_perm_ok = 1'b0;
    endcase
  end

`ifdef PTW_SUPERPAGE_EN
  assign w_super_ok = (i_ppn0 == 10'd0);
`else
  logic w_unused_ppn0;
  assign w_unused_ppn0 = ^i_ppn0;
  assign w_super_ok    = 1'b0;
`endif

  assign o_pointer = !w_invalid && !w_leaf && i_level1;
  assign o_fault   = w_invalid
                  || (!w_leaf && !i_level1)
                  || (w_leaf && (!w_perm_ok || (i_level1 && !w_super_ok)));

endmodule

// File: rtl/page_table_walker.sv
// Two-level page table walker (Sv32-style PTEs, 32-bit physical bus).
// Optional PTW_SUPERPAGE_EN enables 4 MiB leaves at level 1.
module page_table_walker
  import mmu_pkg::*;
#(
  parameter int MEM_LATENCY_MAX = 255
) (
  input  logic        clock,
  input  logic        RST,
  input  logic        req,
  input  logic [31:0] vaddr,
  input  logic [1:0]  accType,
  input  logic [31:0] sptbr,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memValid,
  input  logic [31:0] memRdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] paddr,
  output logic        fault,
  output ptw_state_t  o_state
);

  localparam int CW = (MEM_LATENCY_MAX < 2) ? 1 : $clog2(MEM_LATENCY_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY_MAX - 1);

  ptw_state_t    r_state, w_next;
  logic [31:0]   r_vaddr, r_sptbr, r_paddr;
  logic [1:0]    r_acc;
  logic [19:0]   r_ppn;
  logic [CW-1:0] r_cnt;
  logic          r_fault;

  logic          w_wait, w_level1, w_timeout, w_resolve;
  logic          w_chk_pointer, w_chk_fault;
  logic [31:0]   w_leaf_paddr;
  logic          w_unused_rdata;

  assign w_wait         = (r_state == L1_WAIT) || (r_state == L0_WAIT);
  assign w_level1       = (r_state == L1_WAIT);
  assign w_timeout      = w_wait && !memValid && (r_cnt == CNT_LAST);
  assign w_resolve      = w_wait && memValid && !w_chk_pointer;
  assign w_leaf_paddr   = w_level1 ? {memRdata[29:20], r_vaddr[21:0]}
                                   : {memRdata[29:10], r_vaddr[11:0]};
  assign w_unused_rdata = ^{memRdata[31:30], memRdata[9:4]};

  pte_check u_pte_check (
    .i_flags   (memRdata[3:0]),
    .i_ppn0    (memRdata[19:10]),
    .i_level1  (w_level1),
    .i_acc     (r_acc),
    .o_pointer (w_chk_pointer),
    .o_fault   (w_chk_fault)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req) w_next = L1_REQ;
      L1_REQ:  w_next = L1_WAIT;
      L1_WAIT: begin
        if (memValid)       w_next = w_chk_pointer ? L0_REQ : RESP;
        else if (w_timeout) w_next = RESP;
      end
      L0_REQ:  w_next = L0_WAIT;
      L0_WAIT: if (memValid || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Address is derived from captured registers, so it is stable from REQ through WAIT.
  always_comb begin
    memReq  = 1'b0;
    memAddr = '0;
    case (r_state)
      L1_REQ, L1_WAIT: begin
        memReq  = 1'b1;
        memAddr = r_sptbr + {20'd0, r_vaddr[31:22], 2'b00};
      end
      L0_REQ, L0_WAIT: begin
        memReq  = 1'b1;
        memAddr = {r_ppn, 12'd0} + {20'd0, r_vaddr[21:12], 2'b00};
      end
      default: ;
    endcase
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == RESP);
  assign paddr   = r_paddr;
  assign fault   = r_fault;
  assign o_state = r_state;

  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_vaddr <= '0;
      r_sptbr <= '0;
      r_acc   <= '0;
      r_ppn   <= '0;
      r_cnt   <= '0;
      r_paddr <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_wait ? r_cnt + 1'b1 : '0;
      if (r_state == IDLE && req) begin
        r_vaddr <= vaddr;
        r_sptbr <= sptbr;
        r_acc   <= accType;
        r_paddr <= '0;
        r_fault <= 1'b0;
      end
      if (w_level1 && memValid) r_ppn <= memRdata[29:10];
      if (w_resolve) begin
        r_fault <= w_chk_fault;
        r_paddr <= w_chk_fault ? '0 : w_leaf_paddr;
      end else if (w_timeout) begin
        r_fault <= 1'b1;
        r_paddr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_page_table_walker.sv
// Bench for page_table_walker: directed walks, reset abort, timeout and
// randomized page tables checked against a table-lookup reference model.
module tb_page_table_walker;
  import mmu_pkg::*;

  localparam int LAT = 255;

  logic        clock = 1'b0;
  logic        RST = 1'b1;
  logic        req = 1'b0;
  logic [31:0] vaddr = '0;
  logic [31:0] sptbr = '0;
  logic [1:0]  accType = '0;
  logic        busy, done, fault;
  logic [31:0] paddr;
  ptw_state_t  dbg_state;

  page_table_walker_if mem_if ();

  page_table_walker #(.MEM_LATENCY_MAX(LAT)) dut (
    .clock    (clock),
    .RST      (RST),
    .req      (req),
    .vaddr    (vaddr),
    .accType  (accType),
    .sptbr    (sptbr),
    .memReq   (mem_if.memReq),
    .memAddr  (mem_if.memAddr),
    .memValid (mem_if.memValid),
    .memRdata (mem_if.memRdata),
    .busy     (busy),
    .done     (done),
    .paddr    (paddr),
    .fault    (fault),
    .o_state  (dbg_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pt [logic [31:0]];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pt_rd(input logic [31:0] a);
    return pt.exists(a) ? pt[a] : 32'd0;
  endfunction

  function automatic bit perm_ok(input logic [31:0] p, input logic [1:0] acc);
    if (acc == 2'd0) return p[1] == 1'b1;
    if (acc == 2'd1) return p[2] == 1'b1;
    if (acc == 2'd2) return p[3] == 1'b1;
    return 1'b0;
  endfunction

  // Walks the table in pt; queues the PTE addresses a correct walk must read.
  function automatic void model(input logic [31:0] va, input logic [1:0] acc,
                                input logic [31:0] sp, output logic f,
                                output logic [31:0] pa);
    logic [31:0] a1, p1, a0, p0;
    f = 1'b1;
    pa = 32'd0;
    a1 = sp + (va >> 22) * 4;
    exp_q.push_back(a1);
    p1 = pt_rd(a1);
    if (p1[0] == 1'b0 || (p1[1] == 1'b0 && p1[2] == 1'b1)) return;
    if (p1[1] == 1'b1 || p1[3] == 1'b1) begin
      if (!perm_ok(p1, acc)) return;
`ifdef PTW_SUPERPAGE_EN
      if (((p1 >> 10) & 32'h3ff) != 32'd0) return;
      pa = (((p1 >> 20) & 32'h3ff) << 22) | (va & 32'h3fffff);
      f = 1'b0;
`endif
      return;
    end
    a0 = (((p1 >> 10) & 32'hfffff) << 12) + ((va >> 12) & 32'h3ff) * 4;
    exp_q.push_back(a0);
    p0 = pt_rd(a0);
    if (p0[0] == 1'b0 || (p0[1] == 1'b0 && p0[2] == 1'b1)) return;
    if (p0[1] == 1'b0 && p0[3] == 1'b0) return;
    if (!perm_ok(p0, acc)) return;
    pa = (((p0 >> 10) & 32'hfffff) << 12) | (va & 32'hfff);
    f = 1'b0;
  endfunction

  // Issues one walk, serves PTE reads from pt, returns cycles from req to done.
  task automatic run_walk(input string tag, input logic [31:0] va, input logic [1:0] acc,
                          input logic [31:0] sp, input int fixed_delay, output int cycles);
    logic        exp_f;
    logic [31:0] exp_pa, cur_addr, held_pa;
    bit          active, seen;
    int          wc, dly;
    exp_q.delete();
    model(va, acc, sp, exp_f, exp_pa);
    vaddr = va; accType = acc; sptbr = sp; req = 1'b1;
    step();
    req = 1'b0; vaddr = $urandom; sptbr = $urandom; accType = 2'($urandom_range(0, 3));
    cycles = 1; active = 0; seen = 0; wc = 0; dly = 1; cur_addr = '0;
    for (int i = 0; i < 2000; i++) begin
      mem_if.memValid = 1'b0;
      if (done) begin seen = 1; break; end
      if (mem_if.memReq) begin
        if (!active) begin
          active = 1; wc = 0;
          dly = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 4);
          cur_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdeadbeef;
          chk({tag, " mem_addr"}, mem_if.memAddr, cur_addr);
        end else if (wc == dly) begin
          chk({tag, " mem_addr_hold"}, mem_if.memAddr, cur_addr);
          mem_if.memValid = 1'b1;
          mem_if.memRdata = pt_rd(mem_if.memAddr);
          active = 0;
        end
        wc++;
      end
      step();
      cycles++;
    end
    mem_if.memValid = 1'b0;
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " fault"}, 32'(fault), 32'(exp_f));
    chk({tag, " paddr"}, paddr, exp_pa);
    chk({tag, " accesses_left"}, 32'(exp_q.size()), 32'd0);
    held_pa = exp_pa;
    step();
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " paddr_held"}, paddr, held_pa);
  endtask

  initial begin
    int cyc, n, kind;
    logic [31:0] sp, va, a1, a0, ppn, flags;
    logic [1:0]  acc;

    mem_if.memValid = 1'b0;
    mem_if.memRdata = '0;
    repeat (3) step();
    chk("reset memReq", 32'(mem_if.memReq), 32'd0);
    chk("reset memAddr", mem_if.memAddr, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset paddr", paddr, 32'd0);
    chk("reset fault", 32'(fault), 32'd0);
    chk("reset state", 32'(dbg_state), 32'(IDLE));
    RST = 1'b0;
    step();

    pt.delete();
    pt[32'h14] = 32'h00000401;
    pt[32'h1004] = 32'h00000C03;
    run_walk("two_level", 32'h00401234, ACC_READ, 32'h10, 1, cyc);
    chk("two_level paddr_known", paddr, 32'h00003234);
    chk("two_level fault_known", 32'(fault), 32'd0);

    pt.delete();
    pt[32'h14] = 32'h00000000;
    run_walk("invalid", 32'h00401234, ACC_READ, 32'h10, 1, cyc);
    chk("invalid latency", 32'(cyc), 32'd3);
    chk("invalid fault_known", 32'(fault), 32'd1);
    chk("invalid paddr_known", paddr, 32'd0);

    pt[32'h14] = 32'h00000401;
    pt[32'h1004] = 32'h00000C03;
    run_walk("perm_write", 32'h00401234, ACC_WRITE, 32'h10, 0, cyc);
    chk("perm_write fault_known", 32'(fault), 32'd1);
    run_walk("perm_read", 32'h00401234, ACC_READ, 32'h10, 0, cyc);
    chk("perm_read fault_known", 32'(fault), 32'd0);

    // PPN[1] of 0x00400003 is 4, so the superpage base is 0x01000000.
    pt.delete();
    pt[32'h14] = 32'h00400003;
    run_walk("superpage", 32'h00401234, ACC_READ, 32'h10, 0, cyc);
`ifdef PTW_SUPERPAGE_EN
    chk("superpage fault_known", 32'(fault), 32'd0);
    chk("superpage paddr_known", paddr, 32'h01001234);
`else
    chk("superpage fault_known", 32'(fault), 32'd1);
`endif
    pt[32'h14] = 32'h00400403;
    run_walk("superpage_misaligned", 32'h00401234, ACC_READ, 32'h10, 0, cyc);
    chk("superpage_misaligned fault_known", 32'(fault), 32'd1);

    vaddr = 32'h00401234; sptbr = 32'h10; accType = ACC_READ; req = 1'b1;
    step();
    req = 1'b0;
    step();
    mem_if.memValid = 1'b1; mem_if.memRdata = 32'h00000401;
    step();
    mem_if.memValid = 1'b0;
    step();
    chk("abort in_l0_wait", 32'(dbg_state), 32'(L0_WAIT));
    RST = 1'b1;
    #1;
    chk("abort memReq", 32'(mem_if.memReq), 32'd0);
    chk("abort memAddr", mem_if.memAddr, 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort paddr", paddr, 32'd0);
    chk("abort fault", 32'(fault), 32'd0);
    step();
    RST = 1'b0;
    step();
    mem_if.memValid = 1'b1; mem_if.memRdata = 32'h00000C03;
    step();
    mem_if.memValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort no_done", 32'(done), 32'd0);
      chk("abort stays_idle", 32'(dbg_state), 32'(IDLE));
      step();
    end
    chk("abort paddr_after", paddr, 32'd0);

    pt.delete();
    vaddr = 32'h00401234; sptbr = 32'h10; accType = ACC_READ; req = 1'b1;
    step();
    vaddr = 32'hffff_f000;
    step();
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (done) break;
      vaddr = $urandom;
      step();
      n++;
    end
    chk("timeout done", 32'(done), 32'd1);
    chk("timeout cycles", 32'(n), 32'(LAT));
    chk("timeout fault", 32'(fault), 32'd1);
    chk("timeout paddr", paddr, 32'd0);
    step();
    req = 1'b0;
    chk("timeout req_ignored", 32'(busy), 32'd0);
    step();
    chk("timeout not_queued", 32'(busy), 32'd0);

    for (int t = 0; t < 40; t++) begin
      pt.delete();
      sp = 32'($urandom_range(0, 1023)) << 2;
      va = $urandom;
      acc = 2'($urandom_range(0, 3));
      a1 = sp + (va >> 22) * 4;
      kind = $urandom_range(0, 3);
      flags = 32'($urandom_range(0, 15)) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
      if (kind == 0) begin
        ppn = 32'($urandom_range(16, 255));
        pt[a1] = (ppn << 10) | 32'd1;
        a0 = (ppn << 12) + ((va >> 12) & 32'h3ff) * 4;
        pt[a0] = ($urandom & 32'hFFFFFC00) | flags;
      end else if (kind == 1) begin
        pt[a1] = ($urandom & 32'hFFF00000) | flags;
      end else if (kind == 2) begin
        pt[a1] = $urandom;
      end else begin
        pt[a1] = ($urandom & 32'hFFFFFC00) | flags;
      end
      run_walk("random", va, acc, sp, 0, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
